// File: rtl/alu_multiciclo_if.sv
// Request/response bundle for alu_multiciclo: operands and opcode in, registered result and status out.
interface alu_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [4:0]       CONTROL;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] RESULTADO;
  logic             ZERO;
  logic             VALID;
  logic             BUSY;

  modport master (output START, CONTROL, X, Y, input RESULTADO, ZERO, VALID, BUSY);
  modport slave  (input START, CONTROL, X, Y, output RESULTADO, ZERO, VALID, BUSY);
endinterface

// File: rtl/alu_multiciclo.sv
// RV32/64-style ALU: single-cycle integer ops plus iterative shift-add multiply and
// restoring divide, each taking WIDTH steps on sign-corrected magnitudes.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  alu_multiciclo_if.slave   bus
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, ma_q, ma_d, xo_q, xo_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d, dz_q, dz_d;
  logic             busy;
  logic             xs, ys;
  logic [WIDTH-1:0] mx, my;
  logic [WIDTH:0]   msum, rsh, rsub;

  function automatic logic [WIDTH-1:0] alu_single(input logic [4:0] ctrl,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (ctrl)
      5'b00000: return a + b;
      5'b00111: return a - b;
      5'b00100: return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      5'b01100: return {{(WIDTH-1){1'b0}}, (a < b)};
      5'b00010: return a & b;
      5'b00001: return a | b;
      5'b01001: return a ^ b;
      5'b00110: return {b[WIDTH-1:12], 12'd0};
      5'b00101: return {b[WIDTH-1:12], 12'd0} + a;
      5'b01000: return a << sh;
      5'b01010: return a >> sh;
      5'b01110: return $unsigned($signed(a) >>> sh);
      default:  return '0;
    endcase
  endfunction

  // MUL keeps the low half; every other multiply returns the high half
  function automatic logic [WIDTH-1:0] mul_final(input logic [2:0] op, input logic neg,
                                                 input logic [WIDTH-1:0] hi,
                                                 input logic [WIDTH-1:0] lo);
    logic [2*WIDTH-1:0] p;
    p = neg ? -{hi, lo} : {hi, lo};
    return (op[1:0] == 2'b00) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  // op[1] selects remainder; divide-by-zero bypasses sign correction entirely
  function automatic logic [WIDTH-1:0] div_final(input logic [2:0] op, input logic neg,
                                                 input logic dz, input logic [WIDTH-1:0] rem,
                                                 input logic [WIDTH-1:0] quo,
                                                 input logic [WIDTH-1:0] xo);
    logic [WIDTH-1:0] v;
    if (dz) return op[1] ? xo : '1;
    v = op[1] ? rem : quo;
    return neg ? -v : v;
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    hi_q  <= hi_d;
    lo_q  <= lo_d;
    ma_q  <= ma_d;
    xo_q  <= xo_d;
    op_q  <= op_d;
    neg_q <= neg_d;
    dz_q  <= dz_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.START && bus.CONTROL[4]) state_d = CALC;
      CALC:    if (cnt_q == SHW'(WIDTH-1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ma_d    = ma_q;
    xo_d    = xo_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    // signedness per op: MULH/MULHSU/DIV/REM treat X as signed, MULH/DIV/REM treat Y as signed
    xs      = bus.X[WIDTH-1] & (bus.CONTROL[2:0] inside {3'b001, 3'b010, 3'b100, 3'b110});
    ys      = bus.Y[WIDTH-1] & (bus.CONTROL[2:0] inside {3'b001, 3'b100, 3'b110});
    mx      = xs ? -bus.X : bus.X;
    my      = ys ? -bus.Y : bus.Y;
    msum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, ma_q} : '0);
    rsh     = {hi_q, lo_q[WIDTH-1]};
    rsub    = rsh - {1'b0, ma_q};
    case (state_q)
      IDLE: if (bus.START) begin
        if (bus.CONTROL[4]) begin
          op_d  = bus.CONTROL[2:0];
          cnt_d = '0;
          hi_d  = '0;
          xo_d  = bus.X;
          dz_d  = (bus.Y == '0);
          if (bus.CONTROL[2]) begin
            lo_d  = mx;
            ma_d  = my;
            neg_d = bus.CONTROL[1] ? xs : (xs ^ ys);
          end else begin
            lo_d  = my;
            ma_d  = mx;
            neg_d = xs ^ ys;
          end
        end else begin
          res_d   = alu_single(bus.CONTROL, bus.X, bus.Y);
          valid_d = 1'b1;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          hi_d = (rsh >= {1'b0, ma_q}) ? rsub[WIDTH-1:0] : rsh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], (rsh >= {1'b0, ma_q})};
        end else begin
          hi_d = msum[WIDTH:1];
          lo_d = {msum[0], lo_q[WIDTH-1:1]};
        end
      end
      FIN: begin
        cnt_d   = '0;
        res_d   = op_q[2] ? div_final(op_q, neg_q, dz_q, hi_q, lo_q, xo_q)
                          : mul_final(op_q, neg_q, hi_q, lo_q);
        valid_d = 1'b1;
      end
      default: cnt_d = '0;
    endcase
    if (valid_d) zero_d = (res_d == '0);
  end

  assign bus.RESULTADO = res_q;
  assign bus.ZERO      = zero_q;
  assign bus.VALID     = valid_q;
  assign bus.BUSY      = busy;
endmodule

// File: doc/alu_multiciclo.md
ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; legal values 32 and 64.
REQ-002 The block SHALL have port CLK  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port START  input  1  request strobe; sampled only when BUSY=0.
REQ-005 The block SHALL have port CONTROL  input  5  operation select, sampled with START.
REQ-006 The block SHALL have ports X and Y  input  WIDTH each  operands, sampled with START.
REQ-007 The block SHALL have port RESULTADO  output  WIDTH  registered result, held until the next VALID.
REQ-008 The block SHALL have port ZERO  output  1  registered; high iff RESULTADO is all zeros.
REQ-009 The block SHALL have port VALID  output  1  one-cycle pulse marking a new RESULTADO.
REQ-010 The block SHALL have port BUSY  output  1  high while an iterative operation is in progress.

Function
REQ-011 Single-cycle ops (CONTROL[4]=0) SHALL be: 00000 ADD, 00111 SUB, 00100 SLT (signed), 01100 SLTU, 00010 AND, 00001 OR, 01001 XOR, 00110 LUI ({Y[WIDTH-1:12],12'd0}), 00101 AUIPC ({Y[WIDTH-1:12],12'd0}+X), 01000 SLL, 01010 SRL, 01110 SRA.
REQ-012 Shifts SHALL use only the low log2(WIDTH) bits of Y as shift amount; SRA sign-fills from X[WIDTH-1].
REQ-013 Iterative ops (CONTROL[4]=1) SHALL be: 10000 MUL (low half), 10001 MULH (s x s high), 10010 MULHSU (s x u high), 10011 MULHU (u x u high), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
REQ-014 Any other CONTROL code SHALL be treated as single-cycle with result 0.
REQ-015 Add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-016 State machine SHALL have states IDLE, CALC, FIN; reset enters IDLE.
REQ-017 IDLE, START=1, single-cycle op: result and ZERO registered on that edge, VALID=1 next cycle, stay IDLE (latency 1 edge).
REQ-018 IDLE, START=1, iterative op: operands captured, sign-corrected magnitudes prepared, counter cleared, go to CALC, BUSY=1.
REQ-019 CALC SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per edge for exactly WIDTH edges, then go to FIN.
REQ-020 FIN SHALL apply result sign correction, register RESULTADO/ZERO, pulse VALID, drop BUSY, return to IDLE on the same edge.
REQ-021 Iterative latency SHALL be fixed at WIDTH+2 edges counting the START-sampling edge as edge 1 (34 for WIDTH=32), independent of operand values.
REQ-022 BUSY SHALL be high from the cycle after the START-sampling edge until the edge asserting VALID; BUSY=0 in the VALID cycle, and a START in that cycle SHALL be accepted.
REQ-023 START while BUSY=1 SHALL be ignored; no effect on the operation in progress, no extra VALID.
REQ-024 X, Y, CONTROL changes while BUSY=1 SHALL not affect the result.
REQ-025 Divide by zero: DIV/DIVU SHALL return all ones, REM/REMU SHALL return X, with normal latency.
REQ-026 Signed overflow (X = most negative, Y = -1): DIV SHALL return X, REM SHALL return 0.
REQ-027 DIV/REM SHALL truncate toward zero; REM sign SHALL follow the dividend.
REQ-028 RESULTADO and ZERO SHALL change only on edges that also assert VALID.

Reset
REQ-029 RESET=1 SHALL asynchronously force RESULTADO=0, ZERO=1, VALID=0, BUSY=0, state IDLE, counter 0.
REQ-030 Reset during CALC or FIN SHALL abort the operation with no VALID pulse after release.
REQ-031 The first rising edge after RESET falls SHALL sample START normally.

Verification
REQ-032 ADD X=5, Y=-3 -> RESULTADO=2, ZERO=0, VALID 1 edge after START, BUSY never high.
REQ-033 MUL X=-7, Y=6 -> 0xFFFFFFD6; MULH same operands -> 0xFFFFFFFF; VALID on edge 34, BUSY high 33 cycles.
REQ-034 DIVU X=100, Y=0 -> 0xFFFFFFFF; REMU X=100, Y=0 -> 100; DIV X=0x80000000, Y=-1 -> 0x80000000; REM same -> 0 (ZERO=1).
REQ-035 SRA X=0x80000000, Y=33 -> 0xC0000000; SLL X=1, Y=32 -> 1.
REQ-036 DIV X=-7, Y=2 started, START with ADD pulsed mid-CALC -> single VALID with -3, REM of same -> -1; no ADD result.
REQ-037 RESET pulsed on edge 10 of MULHU -> outputs at reset values, no VALID within 40 cycles; next ADD 1+1 -> 2 after 1 edge.
